// File: rtl/hilo_div_unit_if.sv
// EX-stage and divider-side signals of the HI/LO divide unit.
// master: pipeline plus dividers; slave: the unit itself.
interface hilo_div_unit_if;
  logic [2:0]  op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        flush;
  logic        stall;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        div0;
  logic        err;
  logic [31:0] dvd;
  logic [31:0] dvs;
  logic        sstart;
  logic        ustart;
  logic [31:0] sq;
  logic [31:0] sr;
  logic [31:0] uq;
  logic [31:0] ur;
  logic        sbusy;
  logic        ubusy;

  modport master (
    output op, rs_val, rt_val, flush, sq, sr, uq, ur, sbusy, ubusy,
    input  stall, hi, lo, div0, err, dvd, dvs, sstart, ustart
  );

  modport slave (
    input  op, rs_val, rt_val, flush, sq, sr, uq, ur, sbusy, ubusy,
    output stall, hi, lo, div0, err, dvd, dvs, sstart, ustart
  );
endinterface

// File: rtl/hilo_div_unit.sv
// HI/LO register file with divide issue: launches one of two 32-cycle dividers,
// captures quotient/remainder, and stalls HI/LO-touching ops while a divide is in flight.
module hilo_div_unit #(
  parameter int          WATCHDOG = 40,
  parameter logic [31:0] DIV0_LO  = 32'hFFFFFFFF
) (
  input logic             clock,
  input logic             reset,
  hilo_div_unit_if.slave  bus
);

  localparam int CW = $clog2(WATCHDOG + 1);

  localparam logic [2:0] OP_DIV  = 3'd1;
  localparam logic [2:0] OP_DIVU = 3'd2;
  localparam logic [2:0] OP_MTHI = 3'd3;
  localparam logic [2:0] OP_MTLO = 3'd4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    RUN    = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [31:0]     hi_q, hi_d;
  logic [31:0]     lo_q, lo_d;
  logic [31:0]     dvd_q, dvd_d;
  logic [31:0]     dvs_q, dvs_d;
  logic            signed_q, signed_d;
  logic            seen_q, seen_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            div0_q, div0_d;
  logic            err_q, err_d;
  logic            sstart_c;
  logic            ustart_c;
  logic            sel_busy;
  logic            op_hilo;

  assign sel_busy = signed_q ? bus.sbusy : bus.ubusy;
  assign op_hilo  = (bus.op != 3'd0) && (bus.op != 3'd7);

  always_comb begin
    state_d  = state_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    dvd_d    = dvd_q;
    dvs_d    = dvs_q;
    signed_d = signed_q;
    seen_d   = seen_q;
    cnt_d    = cnt_q;
    div0_d   = 1'b0;
    err_d    = err_q;
    sstart_c = 1'b0;
    ustart_c = 1'b0;

    unique case (state_q)
      IDLE: begin
        // An exception flush also kills whatever op sits in EX this cycle.
        if (!bus.flush) begin
          if (bus.op == OP_MTHI) begin
            hi_d = bus.rs_val;
          end else if (bus.op == OP_MTLO) begin
            lo_d = bus.rs_val;
          end else if (bus.op == OP_DIV || bus.op == OP_DIVU) begin
            if (bus.rt_val == 32'd0) begin
              hi_d   = bus.rs_val;
              lo_d   = DIV0_LO;
              div0_d = 1'b1;
            end else begin
              dvd_d    = bus.rs_val;
              dvs_d    = bus.rt_val;
              signed_d = (bus.op == OP_DIV);
              state_d  = LAUNCH;
            end
          end
        end
      end

      LAUNCH: begin
        if (bus.flush) begin
          state_d = IDLE;
        end else begin
          sstart_c = signed_q;
          ustart_c = !signed_q;
          seen_d   = 1'b0;
          cnt_d    = '0;
          state_d  = RUN;
        end
      end

      RUN: begin
        if (bus.flush) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
          if (sel_busy) begin
            seen_d = 1'b1;
          end
          // Waiting for busy to rise first keeps us from reading stale results.
          if (seen_q && !sel_busy) begin
            lo_d    = signed_q ? bus.sq : bus.uq;
            hi_d    = signed_q ? bus.sr : bus.ur;
            state_d = IDLE;
          end else if (cnt_q == CW'(WATCHDOG - 1)) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      hi_q     <= '0;
      lo_q     <= '0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      signed_q <= 1'b0;
      seen_q   <= 1'b0;
      cnt_q    <= '0;
      div0_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      dvd_q    <= dvd_d;
      dvs_q    <= dvs_d;
      signed_q <= signed_d;
      seen_q   <= seen_d;
      cnt_q    <= cnt_d;
      div0_q   <= div0_d;
      err_q    <= err_d;
    end
  end

  assign bus.stall  = (state_q != IDLE) && op_hilo;
  assign bus.hi     = hi_q;
  assign bus.lo     = lo_q;
  assign bus.div0   = div0_q;
  assign bus.err    = err_q;
  assign bus.dvd    = dvd_q;
  assign bus.dvs    = dvs_q;
  assign bus.sstart = sstart_c;
  assign bus.ustart = ustart_c;

endmodule

// File: tb/tb_hilo_div_unit.sv
// Directed bench for hilo_div_unit with behavioural 32-cycle signed/unsigned dividers.
module tb_hilo_div_unit;

  localparam logic [2:0] NOP  = 3'd0;
  localparam logic [2:0] DIV  = 3'd1;
  localparam logic [2:0] DIVU = 3'd2;
  localparam logic [2:0] MTHI = 3'd3;
  localparam logic [2:0] MTLO = 3'd4;
  localparam logic [2:0] MFHI = 3'd5;
  localparam logic [2:0] MFLO = 3'd6;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic kill  = 1'b0;
  int   n_asrt = 0;
  int   n_fail = 0;
  int   s_left = 0;
  int   u_left = 0;
  logic saw_u;
  logic bad;

  hilo_div_unit_if bus ();

  hilo_div_unit #(.WATCHDOG(40), .DIV0_LO(32'hFFFFFFFF)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  // Divider models: busy for 32 cycles after the start edge, restartable.
  always @(posedge clock) begin
    if (bus.sstart) begin
      s_left <= 32;
      bus.sq <= $signed(bus.dvd) / $signed(bus.dvs);
      bus.sr <= $signed(bus.dvd) % $signed(bus.dvs);
    end else if (s_left > 0) begin
      s_left <= s_left - 1;
    end
    if (bus.ustart) begin
      u_left <= 32;
      bus.uq <= bus.dvd / bus.dvs;
      bus.ur <= bus.dvd % bus.dvs;
    end else if (u_left > 0) begin
      u_left <= u_left - 1;
    end
  end

  assign bus.sbusy = (s_left != 0) && !kill;
  assign bus.ubusy = (u_left != 0);

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    bus.op = NOP; bus.rs_val = '0; bus.rt_val = '0; bus.flush = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_hi", bus.hi, 32'd0);
    chk("rst_lo", bus.lo, 32'd0);
    chk("rst_dvd", bus.dvd, 32'd0);
    chk("rst_dvs", bus.dvs, 32'd0);
    chk("rst_flags", {28'd0, bus.sstart, bus.ustart, bus.div0, bus.err}, 32'd0);
    reset = 1'b0;
    tick();

    // DIV -7 / 2, signed path
    bus.op = DIV; bus.rs_val = 32'hFFFFFFF9; bus.rt_val = 32'd2;
    #1 chk("t1_stall_issue", {31'd0, bus.stall}, 32'd0);
    tick();
    bus.op = NOP;
    #1 chk("t1_sstart", {31'd0, bus.sstart}, 32'd1);
    chk("t1_ustart", {31'd0, bus.ustart}, 32'd0);
    chk("t1_dvd", bus.dvd, 32'hFFFFFFF9);
    saw_u = 1'b0;
    for (int c = 2; c <= 34; c++) begin
      tick();
      saw_u |= bus.ustart;
    end
    chk("t1_hi_c34", bus.hi, 32'd0);
    tick();
    chk("t1_lo", bus.lo, 32'hFFFFFFFD);
    chk("t1_hi", bus.hi, 32'hFFFFFFFF);
    chk("t1_no_ustart", {31'd0, saw_u}, 32'd0);

    // DIVU 0xFFFFFFFF / 16 with dependent MFLO
    bus.op = DIVU; bus.rs_val = 32'hFFFFFFFF; bus.rt_val = 32'd16;
    tick();
    bus.op = MFLO;
    for (int c = 1; c <= 34; c++) begin
      #1 chk($sformatf("t2_stall_c%0d", c), {31'd0, bus.stall}, 32'd1);
      tick();
    end
    #1 chk("t2_stall_c35", {31'd0, bus.stall}, 32'd0);
    chk("t2_lo", bus.lo, 32'h0FFFFFFF);
    chk("t2_hi", bus.hi, 32'h0000000F);
    bus.op = NOP;
    tick();

    // Divide by zero
    bus.op = DIV; bus.rs_val = 32'h12345678; bus.rt_val = 32'd0;
    #1 chk("t3_stall_issue", {31'd0, bus.stall}, 32'd0);
    tick();
    bus.op = MFHI;
    #1 chk("t3_hi", bus.hi, 32'h12345678);
    chk("t3_lo", bus.lo, 32'hFFFFFFFF);
    chk("t3_div0", {31'd0, bus.div0}, 32'd1);
    chk("t3_nostart", {30'd0, bus.sstart, bus.ustart}, 32'd0);
    chk("t3_stall", {31'd0, bus.stall}, 32'd0);
    tick();
    bus.op = NOP;
    #1 chk("t3_div0_pulse", {31'd0, bus.div0}, 32'd0);

    // DIVU 100/7 flushed in cycle 10, DIVU 9/4 in cycle 11
    bus.op = DIVU; bus.rs_val = 32'd100; bus.rt_val = 32'd7;
    tick();
    bus.op = NOP;
    for (int c = 1; c <= 9; c++) tick();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    bus.op = DIVU; bus.rs_val = 32'd9; bus.rt_val = 32'd4;
    #1 chk("t4_stall_after_flush", {31'd0, bus.stall}, 32'd0);
    chk("t4_hi_kept", bus.hi, 32'h12345678);
    chk("t4_lo_kept", bus.lo, 32'hFFFFFFFF);
    tick();
    bus.op = NOP;
    #1 chk("t4_ustart", {31'd0, bus.ustart}, 32'd1);
    bad = 1'b0;
    for (int c = 13; c <= 46; c++) begin
      tick();
      bad |= (bus.lo == 32'd14) && (bus.hi == 32'd2);
    end
    chk("t4_lo", bus.lo, 32'd2);
    chk("t4_hi", bus.hi, 32'd1);
    chk("t4_no_flushed_result", {31'd0, bad}, 32'd0);

    // Back-to-back MTHI/MTLO
    bus.op = MTHI; bus.rs_val = 32'hAAAA0000;
    #1 chk("t5_stall_mthi", {31'd0, bus.stall}, 32'd0);
    tick();
    bus.op = MTLO; bus.rs_val = 32'h00005555;
    #1 chk("t5_stall_mtlo", {31'd0, bus.stall}, 32'd0);
    chk("t5_hi", bus.hi, 32'hAAAA0000);
    chk("t5_lo_old", bus.lo, 32'd2);
    tick();
    bus.op = NOP;
    #1 chk("t5_lo", bus.lo, 32'h00005555);

    // Reset in cycle 20 of a DIV
    bus.op = DIV; bus.rs_val = 32'd50; bus.rt_val = 32'd5;
    tick();
    bus.op = NOP;
    for (int c = 1; c <= 19; c++) tick();
    reset = 1'b1;
    #1 chk("t5r_hi", bus.hi, 32'd0);
    chk("t5r_lo", bus.lo, 32'd0);
    bus.op = MFHI;
    #1 chk("t5r_stall_in_reset", {31'd0, bus.stall}, 32'd0);
    tick();
    reset = 1'b0;
    tick();
    chk("t5r_stall_after", {31'd0, bus.stall}, 32'd0);
    chk("t5r_lo_after", bus.lo, 32'd0);
    bus.op = NOP;

    // Watchdog: signed busy never rises
    bus.op = MTHI; bus.rs_val = 32'h1111;
    tick();
    bus.op = MTLO; bus.rs_val = 32'h2222;
    tick();
    kill = 1'b1;
    bus.op = DIV; bus.rs_val = 32'd10; bus.rt_val = 32'd3;
    tick();
    bus.op = MFHI;
    for (int c = 1; c <= 40; c++) tick();
    chk("t6_err_c41", {31'd0, bus.err}, 32'd0);
    chk("t6_stall_c41", {31'd0, bus.stall}, 32'd1);
    tick();
    chk("t6_err", {31'd0, bus.err}, 32'd1);
    chk("t6_stall_c42", {31'd0, bus.stall}, 32'd0);
    chk("t6_hi", bus.hi, 32'h1111);
    chk("t6_lo", bus.lo, 32'h2222);
    bus.op = NOP;
    tick();
    chk("t6_err_sticky", {31'd0, bus.err}, 32'd1);
    kill = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
